// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply-accumulate: unsigned x signed products summed over first..last framed
// beats. The result is held on a single-entry output register with valid/ready backpressure.
module myproject_mac_pipe #(
    parameter int unsigned ID         = 1,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned din0_WIDTH = 24,
    parameter int unsigned din1_WIDTH = 18,
    parameter int unsigned dout_WIDTH = 48,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0]  out_terms,
    output logic                  out_ovf
);

    localparam int unsigned PROD_W = din0_WIDTH + din1_WIDTH + 1;
    localparam int unsigned SUM_W  = dout_WIDTH + 1;
    // ID is an instance tag only; folding it in as zero keeps it referenced
    localparam int unsigned LAST   = NUM_STAGE - 1 + 0 * ID;
    localparam logic [dout_WIDTH-1:0] ACC_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] ACC_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    logic stall;

    // input capture stage
    logic                  in_v, in_f, in_l;
    logic [din0_WIDTH-1:0] in_a;
    logic [din1_WIDTH-1:0] in_b;

    // product pipeline with framing tags
    logic                         pv [NUM_STAGE];
    logic                         pf [NUM_STAGE];
    logic                         pl [NUM_STAGE];
    logic signed [dout_WIDTH-1:0] pp [NUM_STAGE];

    logic signed [PROD_W-1:0]     prod_full;
    logic signed [dout_WIDTH-1:0] prod_ext;

    logic signed [dout_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_WIDTH-1:0]         cnt, cnt_nxt;
    logic                         ovf, ovf_nxt;
    logic signed [SUM_W-1:0]      sum;
    logic                         add_ovf;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // zero-extended din0 keeps the multiplicand non-negative
    assign prod_full = PROD_W'($signed({1'b0, in_a})) * PROD_W'($signed(in_b));
    assign prod_ext  = dout_WIDTH'(prod_full);

    // accumulator update for the beat leaving the pipeline
    always_comb begin
        sum     = SUM_W'(acc) + SUM_W'(pp[LAST]);
        add_ovf = sum[SUM_W-1] != sum[SUM_W-2];
        acc_nxt = sum[dout_WIDTH-1:0];
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (pf[LAST]) begin
            acc_nxt = pp[LAST];
            cnt_nxt = CNT_WIDTH'(1);
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf | add_ovf;
            if (add_ovf && (SATURATE != 0)) begin
                acc_nxt = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
            end
            if (!(&cnt)) begin
                cnt_nxt = cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            in_v <= 1'b0;
            in_f <= 1'b0;
            in_l <= 1'b0;
            in_a <= '0;
            in_b <= '0;
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                pv[i] <= 1'b0;
                pf[i] <= 1'b0;
                pl[i] <= 1'b0;
                pp[i] <= '0;
            end
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_terms <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            // in_ready is high here, so in_valid alone marks an accepted beat
            in_v <= in_valid;
            in_f <= in_first;
            in_l <= in_last;
            in_a <= din0;
            in_b <= din1;
            pv[0] <= in_v;
            pf[0] <= in_f;
            pl[0] <= in_l;
            pp[0] <= prod_ext;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pl[i] <= pl[i-1];
                pp[i] <= pp[i-1];
            end
            if (pv[LAST]) begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                ovf <= ovf_nxt;
            end
            if (pv[LAST] && pl[LAST]) begin
                out_valid <= 1'b1;
                dout      <= acc_nxt;
                out_terms <= cnt_nxt;
                out_ovf   <= ovf_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: default instance plus two 43-bit instances
// (saturating and wrapping) sharing one stimulus stream.
module tb_myproject_mac_pipe;

    logic        ap_clk;
    logic        ap_rst;
    logic        in_valid;
    logic [23:0] din0;
    logic [17:0] din1;
    logic        in_first;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [47:0] dout;
    logic [15:0] out_terms;

    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [42:0] dout_s;
    logic [15:0] out_terms_s;

    logic        in_ready_w, out_valid_w, out_ovf_w;
    logic [42:0] dout_w;
    logic [15:0] out_terms_w;

    int n_checks = 0;
    int n_fail   = 0;

    longint res_q[$];
    int     terms_q[$];
    logic   ovf_q[$];
    longint sat_q[$];
    int     sat_terms_q[$];
    logic   sat_ovf_q[$];
    longint wrap_q[$];
    logic   wrap_ovf_q[$];

    myproject_mac_pipe dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .out_terms(out_terms), .out_ovf(out_ovf)
    );

    myproject_mac_pipe #(.dout_WIDTH(43), .SATURATE(1)) dut_sat (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s),
        .out_terms(out_terms_s), .out_ovf(out_ovf_s)
    );

    myproject_mac_pipe #(.dout_WIDTH(43), .SATURATE(0)) dut_wrap (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .dout(dout_w),
        .out_terms(out_terms_w), .out_ovf(out_ovf_w)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // record every handshaken result
    always @(posedge ap_clk) begin
        if (!ap_rst && out_valid && out_ready) begin
            res_q.push_back(longint'($signed(dout)));
            terms_q.push_back(int'(out_terms));
            ovf_q.push_back(out_ovf);
        end
        if (!ap_rst && out_valid_s && out_ready) begin
            sat_q.push_back(longint'($signed(dout_s)));
            sat_terms_q.push_back(int'(out_terms_s));
            sat_ovf_q.push_back(out_ovf_s);
        end
        if (!ap_rst && out_valid_w && out_ready) begin
            wrap_q.push_back(longint'($signed(dout_w)));
            wrap_ovf_q.push_back(out_ovf_w);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input int a, input int b, input logic f, input logic l);
        int tries = 0;
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = 24'(a);
        din1     = 18'(b);
        in_first = f;
        in_last  = l;
        #1;
        while (!in_ready && tries < 50) begin
            @(negedge ap_clk);
            #1;
            tries++;
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input longint d, input int terms, input logic ovf);
        int n = 0;
        while (res_q.size() == 0 && n < 50) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk({tag, "_present"}, longint'(res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
            chk({tag, "_dout"}, res_q.pop_front(), d);
            chk({tag, "_terms"}, longint'(terms_q.pop_front()), longint'(terms));
            chk({tag, "_ovf"}, longint'(ovf_q.pop_front()), longint'(ovf));
        end
    endtask

    initial begin
        int lat;
        int n;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        din0      = '0;
        din1      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_dout", longint'(dout), 0);
        chk("rst_terms", longint'(out_terms), 0);
        chk("rst_ovf", longint'(out_ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);

        // single first+last beat and its latency
        send(3, -5, 1'b1, 1'b1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge ap_clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", longint'(lat), 3);
        expect_result("single", -15, 1, 1'b0);

        // four back-to-back beats
        send(1, 2, 1'b1, 1'b0);
        send(3, 4, 1'b0, 1'b0);
        send(5, -6, 1'b0, 1'b0);
        send(7, 8, 1'b0, 1'b1);
        expect_result("four", 40, 4, 1'b0);

        // extreme operands: din0 must stay unsigned
        send(16777215, -131072, 1'b1, 1'b1);
        expect_result("extreme", -64'sd2199023124480, 1, 1'b0);

        // backpressure: two results, downstream stalled for 5 cycles
        @(negedge ap_clk);
        out_ready = 1'b0;
        send(2, 3, 1'b1, 1'b1);
        send(4, 5, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk("stall_seen", longint'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge ap_clk);
            #1;
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_dout", longint'($signed(dout)), 6);
        end
        chk("stall_sat_in_ready", longint'(in_ready_s), 0);
        chk("stall_wrap_in_ready", longint'(in_ready_w), 0);
        @(negedge ap_clk);
        out_ready = 1'b1;
        expect_result("stall_a", 6, 1, 1'b0);
        expect_result("stall_b", 20, 1, 1'b0);

        // overflow on the 43-bit instances, with bubbles between beats
        repeat (3) @(posedge ap_clk);
        sat_q.delete();
        sat_terms_q.delete();
        sat_ovf_q.delete();
        wrap_q.delete();
        wrap_ovf_q.delete();
        send(16777215, 131071, 1'b1, 1'b0);
        repeat (2) @(posedge ap_clk);
        send(16777215, 131071, 1'b0, 1'b0);
        repeat (1) @(posedge ap_clk);
        send(16777215, 131071, 1'b0, 1'b1);
        expect_result("wide3", 64'sd6597019041795, 3, 1'b0);
        repeat (2) @(posedge ap_clk);
        chk("sat_present", longint'(sat_q.size()), 1);
        if (sat_q.size() > 0) begin
            chk("sat_dout", sat_q.pop_front(), 64'sd4398046511103);
            chk("sat_terms", longint'(sat_terms_q.pop_front()), 3);
            chk("sat_ovf", longint'(sat_ovf_q.pop_front()), 1);
        end
        chk("wrap_present", longint'(wrap_q.size()), 1);
        if (wrap_q.size() > 0) begin
            chk("wrap_dout", wrap_q.pop_front(), -64'sd2199073980413);
            chk("wrap_ovf", longint'(wrap_ovf_q.pop_front()), 1);
        end

        // reset mid-accumulation discards in-flight beats
        send(1, 1, 1'b1, 1'b0);
        send(1, 1, 1'b0, 1'b0);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (8) @(posedge ap_clk);
        #1;
        chk("rst_mid_no_result", longint'(res_q.size()), 0);
        chk("rst_mid_out_valid", longint'(out_valid), 0);

        // beats without a preceding first accumulate from zero
        send(2, 3, 1'b0, 1'b1);
        expect_result("nofirst", 6, 1, 1'b0);
        send(5, -1, 1'b0, 1'b1);
        expect_result("nofirst_cont", 1, 2, 1'b0);
        send(2, 3, 1'b1, 1'b1);
        expect_result("after_rst", 6, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
